mem_req_arbiter: RTL and testbench

Shares the single SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stage) using a req / addr_ok / data_ok handshake. Data requests have priority; a grant is locked until addr_ok is returned. An in-order owner FIFO routes each data_ok/rdata back to the requester that issued the address. A flush discards responses to instruction fetches already in flight, so a redirected IF stage never sees stale instructions.

---
 rtl/cpu_bus_pkg.sv | 19 +
 rtl/mem_req_arbiter_owner_fifo.sv | 74 +++++++
 rtl/mem_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side SRAM-like bus: owner encoding,
// transfer size codes and the pipeline bubble instruction.
package cpu_bus_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0280_0000;

  // An entry that belongs to the fetch side and may be invalidated by a flush.
  function automatic logic is_inst_owner(input logic owner);
    return (owner == OWN_INST);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// In-order record of which requester owns each accepted-but-unanswered
// transaction, with a per-entry discard flag that flush sets on fetches.
module owner_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_owner,
  input  logic pop,
  input  logic flush_inst,
  output logic full,
  output logic empty,
  output logic head_owner,
  output logic head_discard
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] owner_r;
  logic [DEPTH-1:0] discard_r;
  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // A flush in the same cycle as the response also kills a fetch at the head.
  assign head_owner   = owner_r[rptr_r];
  assign head_discard = discard_r[rptr_r] | (flush_inst && is_inst_owner(owner_r[rptr_r]));

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wptr_r <= wptr_r + PW'(1);
      if (pop_ok_s)  rptr_r <= rptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; stale slots may get marked by flush, harmless since a push rewrites both bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_r   <= {DEPTH{1'b0}};
      discard_r <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok_s && (wptr_r == PW'(i))) begin
          owner_r[i]   <= push_owner;
          discard_r[i] <= flush_inst && is_inst_owner(push_owner);
        end else if (flush_inst && is_inst_owner(owner_r[i])) begin
          discard_r[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// Data wins when unlocked, a pending grant is held until addr_ok, and
// responses are steered back in order through the owner FIFO.
module mem_req_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int OUTSTANDING_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic [3:0]  inst_wstrb,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        busy,
  output logic        protocol_err
);

  logic lock_valid_r;
  logic lock_owner_r;
  logic protocol_err_r;
  logic lock_eff_s;
  logic sel_owner_s;
  logic sel_req_s;
  logic accept_s;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic head_owner_s;
  logic head_discard_s;
  logic deliver_s;

  // A flush abandons a half-granted fetch, so the fetch lock stops counting at once.
  assign lock_eff_s = lock_valid_r && !(flush && is_inst_owner(lock_owner_r));

  // Pick the owner: held lock first, then data over fetch.
  always_comb begin
    sel_owner_s = OWN_INST;
    if (lock_eff_s) begin
      sel_owner_s = lock_owner_r;
    end else if (data_req) begin
      sel_owner_s = OWN_DATA;
    end else begin
      sel_owner_s = OWN_INST;
    end
  end

  // Forward the selected requester's request and payload downstream.
  always_comb begin
    sel_req_s = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = SZ_BYTE;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_wstrb = 4'h0;
    if (sel_owner_s == OWN_DATA) begin
      sel_req_s = data_req;
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_wstrb = data_wstrb;
    end else begin
      sel_req_s = inst_req;
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
      mem_wstrb = inst_wstrb;
    end
  end

  assign mem_req      = sel_req_s && !fifo_full_s;
  assign accept_s     = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept_s && (sel_owner_s == OWN_INST);
  assign data_addr_ok = accept_s && (sel_owner_s == OWN_DATA);

  // Hold the grant while a request is on the bus but not yet accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid_r <= 1'b0;
      lock_owner_r <= OWN_INST;
    end else if (accept_s) begin
      lock_valid_r <= 1'b0;
    end else if (mem_req) begin
      lock_valid_r <= 1'b1;
      lock_owner_r <= sel_owner_s;
    end else if (flush && is_inst_owner(lock_owner_r)) begin
      lock_valid_r <= 1'b0;
    end
  end

  owner_fifo #(
    .DEPTH (OUTSTANDING_DEPTH)
  ) u_owner_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push         (accept_s),
    .push_owner   (sel_owner_s),
    .pop          (mem_data_ok),
    .flush_inst   (flush),
    .full         (fifo_full_s),
    .empty        (fifo_empty_s),
    .head_owner   (head_owner_s),
    .head_discard (head_discard_s)
  );

  assign deliver_s    = mem_data_ok && !fifo_empty_s && !head_discard_s;
  assign inst_data_ok = deliver_s && (head_owner_s == OWN_INST);
  assign data_data_ok = deliver_s && (head_owner_s == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0000_0000;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0000_0000;
  assign busy         = !fifo_empty_s;
  assign protocol_err = protocol_err_r;

  // A response with nothing outstanding is a downstream protocol violation; sticky until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      protocol_err_r <= 1'b0;
    end else if (mem_data_ok && fifo_empty_s) begin
      protocol_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a per-cycle vector table covering
// fetch/data arbitration, locking, full FIFO, flush and store responses,
// followed by hand-written reset and protocol-error sequences.
module tb_mem_req_arbiter;
  import cpu_bus_pkg::*;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        busy;
  logic        protocol_err;

  int checks   = 0;
  int failures = 0;

  mem_req_arbiter #(.OUTSTANDING_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_wstrb(inst_wstrb),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .flush(flush), .busy(busy), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_bits = {inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok, flush}
  // ex      = {mem_req, mem_wr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, protocol_err}
  typedef struct packed {
    logic [5:0]  in_bits;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] rd;
    logic [7:0]  ex;
    logic [31:0] ma;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mkv(input logic [5:0] in_bits, input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] rd, input logic [7:0] ex, input logic [31:0] ma,
                               input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.in_bits = in_bits; v.ia = ia; v.da = da; v.rd = rd;
    v.ex = ex; v.ma = ma; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [103:0] observed();
    return {mem_req, mem_wr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
            busy, protocol_err, mem_addr, inst_rdata, data_rdata};
  endfunction

  task automatic drive(input vec_t v);
    {inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok, flush} = v.in_bits;
    inst_addr = v.ia;
    data_addr = v.da;
    mem_rdata = v.rd;
  endtask

  task automatic idle();
    {inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok, flush} = 6'b000000;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    inst_wr = 1'b0; inst_size = SZ_WORD; inst_wdata = 32'h0000_0000; inst_wstrb = 4'hF;
    data_size = SZ_HALF; data_wdata = 32'hCAFE_F00D; data_wstrb = 4'h3;
    inst_addr = 32'h1C00_0000; data_addr = 32'h0000_0000; mem_rdata = 32'h0000_0000;

    // Fetch read, then both requesting, then a held fetch grant with data waiting.
    tbl[0]  = mkv(6'b100100, 32'h1C00_0000, 32'h0, 32'h0,          8'b10100000, 32'h1C00_0000, 32'h0, 32'h0);
    tbl[1]  = mkv(6'b000010, 32'h1C00_0000, 32'h0, 32'h1C00_0000,  8'b00001010, 32'h1C00_0000, 32'h1C00_0000, 32'h0);
    tbl[2]  = mkv(6'b110100, 32'h1C00_0008, 32'h1000, 32'h0,       8'b10010000, 32'h0000_1000, 32'h0, 32'h0);
    tbl[3]  = mkv(6'b100110, 32'h1C00_0008, 32'h1000, 32'hAAAA_0001, 8'b10100110, 32'h1C00_0008, 32'h0, 32'hAAAA_0001);
    tbl[4]  = mkv(6'b000010, 32'h1C00_0008, 32'h1000, NOP_INST,    8'b00001010, 32'h1C00_0008, NOP_INST, 32'h0);
    tbl[5]  = mkv(6'b100000, 32'h1C00_0010, 32'h2000, 32'h0,       8'b10000000, 32'h1C00_0010, 32'h0, 32'h0);
    tbl[6]  = mkv(6'b110000, 32'h1C00_0010, 32'h2000, 32'h0,       8'b10000000, 32'h1C00_0010, 32'h0, 32'h0);
    tbl[7]  = mkv(6'b110000, 32'h1C00_0010, 32'h2000, 32'h0,       8'b10000000, 32'h1C00_0010, 32'h0, 32'h0);
    tbl[8]  = mkv(6'b110100, 32'h1C00_0010, 32'h2000, 32'h0,       8'b10100000, 32'h1C00_0010, 32'h0, 32'h0);
    tbl[9]  = mkv(6'b010100, 32'h1C00_0010, 32'h2000, 32'h0,       8'b10010010, 32'h0000_2000, 32'h0, 32'h0);
    // FIFO full: third request blocked, even with a pop in the same cycle.
    tbl[10] = mkv(6'b010100, 32'h1C00_0010, 32'h3000, 32'h0,       8'b00000010, 32'h0000_3000, 32'h0, 32'h0);
    tbl[11] = mkv(6'b010110, 32'h1C00_0010, 32'h3000, 32'h1111_1111, 8'b00001010, 32'h0000_3000, 32'h1111_1111, 32'h0);
    tbl[12] = mkv(6'b010100, 32'h1C00_0010, 32'h3000, 32'h0,       8'b10010010, 32'h0000_3000, 32'h0, 32'h0);
    tbl[13] = mkv(6'b000010, 32'h1C00_0010, 32'h3000, 32'h2222_2222, 8'b00000110, 32'h1C00_0010, 32'h0, 32'h2222_2222);
    tbl[14] = mkv(6'b000010, 32'h1C00_0010, 32'h3000, 32'h3333_3333, 8'b00000110, 32'h1C00_0010, 32'h0, 32'h3333_3333);
    // Flush after a fetch and a store are outstanding.
    tbl[15] = mkv(6'b100100, 32'h1C00_0004, 32'h4000, 32'h0,       8'b10100000, 32'h1C00_0004, 32'h0, 32'h0);
    tbl[16] = mkv(6'b011100, 32'h1C00_0004, 32'h4000, 32'h0,       8'b11010010, 32'h0000_4000, 32'h0, 32'h0);
    tbl[17] = mkv(6'b000001, 32'h1C00_0004, 32'h4000, 32'h0,       8'b00000010, 32'h1C00_0004, 32'h0, 32'h0);
    tbl[18] = mkv(6'b000010, 32'h1C00_0004, 32'h4000, 32'hDEAD_BEEF, 8'b00000010, 32'h1C00_0004, 32'h0, 32'h0);
    tbl[19] = mkv(6'b000010, 32'h1C00_0004, 32'h4000, 32'h5A5A_5A5A, 8'b00000110, 32'h1C00_0004, 32'h0, 32'h5A5A_5A5A);
    tbl[20] = mkv(6'b000000, 32'h1C00_0004, 32'h4000, 32'h0,       8'b00000000, 32'h1C00_0004, 32'h0, 32'h0);
    // Flush in the same cycle a fetch is accepted.
    tbl[21] = mkv(6'b100101, 32'h1C00_0020, 32'h4000, 32'h0,       8'b10100000, 32'h1C00_0020, 32'h0, 32'h0);
    tbl[22] = mkv(6'b000010, 32'h1C00_0020, 32'h4000, 32'h5555_5555, 8'b00000010, 32'h1C00_0020, 32'h0, 32'h0);
    // Flush drops a held fetch grant so data gets through immediately.
    tbl[23] = mkv(6'b100000, 32'h1C00_0030, 32'h5000, 32'h0,       8'b10000000, 32'h1C00_0030, 32'h0, 32'h0);
    tbl[24] = mkv(6'b010101, 32'h1C00_0030, 32'h5000, 32'h0,       8'b10010000, 32'h0000_5000, 32'h0, 32'h0);
    tbl[25] = mkv(6'b000010, 32'h1C00_0030, 32'h5000, 32'h6666_6666, 8'b00000110, 32'h1C00_0030, 32'h0, 32'h6666_6666);
    tbl[26] = mkv(6'b000000, 32'h1C00_0030, 32'h5000, 32'h0,       8'b00000000, 32'h1C00_0030, 32'h0, 32'h0);

    // Reset state (inst_addr idles at 0x1C000000 so mem_addr follows the fetch side).
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", observed(), {8'b00000000, 32'h1C00_0000, 32'h0, 32'h0});
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d", i), observed(), {tbl[i].ex, tbl[i].ma, tbl[i].ird, tbl[i].drd});
    end

    // Store payload is forwarded from the data side.
    @(negedge clk);
    idle();
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_6000;
    #1;
    chk("store_payload", {72'h0, mem_req, mem_wr, mem_size, mem_wstrb, mem_wdata, mem_addr},
        {72'h0, 1'b1, 1'b1, SZ_HALF, 4'h3, 32'hCAFE_F00D, 32'h0000_6000});

    // Async reset with a transaction outstanding clears everything at once.
    mem_addr_ok = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("busy_before_reset", {103'h0, busy}, {103'h0, 1'b1});
    resetn = 1'b0;
    #1;
    chk("async_reset_clear", {102'h0, busy, lock_and_err()}, 104'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Response with an empty FIFO: ignored, then protocol_err sticks.
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    chk("stray_resp_no_dataok", {100'h0, inst_data_ok, data_data_ok, busy, protocol_err}, 104'h0);
    @(negedge clk);
    idle();
    #1;
    chk("perr_set", {103'h0, protocol_err}, {103'h0, 1'b1});
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1C00_0040; mem_addr_ok = 1'b1;
    #1;
    chk("perr_sticky_traffic", {101'h0, inst_addr_ok, busy, protocol_err}, {101'h0, 1'b1, 1'b0, 1'b1});
    @(negedge clk);
    idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h8888_8888;
    #1;
    chk("perr_sticky_resp", {35'h0, inst_data_ok, protocol_err, inst_rdata, 35'h0},
        {35'h0, 1'b1, 1'b1, 32'h8888_8888, 35'h0});
    @(negedge clk);
    idle();
    resetn = 1'b0;
    #1;
    chk("perr_cleared_by_reset", {103'h0, protocol_err}, 104'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [1:0] lock_and_err();
    return {mem_req, protocol_err};
  endfunction

endmodule
